// File: rtl/regbank_wbq.sv
// regbank_wbq: eight-entry register bank with an in-order write queue.
//
// Write-back requests (wb_*) are accepted into a DEPTH-entry FIFO while it has
// room. The head entry commits to its target register on any edge where
// commit_en is high. Register outputs are straight from the flops, so a queued
// write is never bypassed to r0..r7. The pending vector flags registers with
// outstanding queued writes for hazard detection.
//
// Ports:
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   wb_valid/wb_ready   write request handshake; ready = queue not full
//   wb_addr             target register index
//   wb_mode             00 word, 01 low byte, 10 high byte, 11 accumulate
//   wb_data             write operand
//   commit_en           allow the head entry to commit this cycle
//   r0..r7              register contents
//   pending             bit i set while any queued entry targets register i
//   q_count             number of queued entries
//   commit_pulse        high for one cycle after each commit
//   commit_addr         index of the most recently committed entry
//
// WIDTH must be at least 16 so the byte lanes are well defined.
module regbank_wbq #(
  parameter int WIDTH   = 16,
  parameter int DEPTH   = 2,
  parameter int ZERO_R0 = 0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       wb_valid,
  output logic                       wb_ready,
  input  logic [2:0]                 wb_addr,
  input  logic [1:0]                 wb_mode,
  input  logic [WIDTH-1:0]           wb_data,
  input  logic                       commit_en,
  output logic [WIDTH-1:0]           r0,
  output logic [WIDTH-1:0]           r1,
  output logic [WIDTH-1:0]           r2,
  output logic [WIDTH-1:0]           r3,
  output logic [WIDTH-1:0]           r4,
  output logic [WIDTH-1:0]           r5,
  output logic [WIDTH-1:0]           r6,
  output logic [WIDTH-1:0]           r7,
  output logic [7:0]                 pending,
  output logic [$clog2(DEPTH+1)-1:0] q_count,
  output logic                       commit_pulse,
  output logic [2:0]                 commit_addr
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [PW-1:0] LAST_P  = PW'(DEPTH - 1);

  // Advance a queue pointer, wrapping at DEPTH.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    if (p == LAST_P) begin
      return {PW{1'b0}};
    end else begin
      return p + PW'(1);
    end
  endfunction

  logic [2:0]       q_addr [DEPTH];
  logic [1:0]       q_mode [DEPTH];
  logic [WIDTH-1:0] q_data [DEPTH];
  logic [DEPTH-1:0] q_vld;
  logic [PW-1:0]    head;
  logic [PW-1:0]    tail;
  logic [CW-1:0]    count;
  logic [CW-1:0]    count_next;
  logic [WIDTH-1:0] regs [8];

  logic             enq;
  logic             deq;
  logic [2:0]       head_addr;
  logic [1:0]       head_mode;
  logic [WIDTH-1:0] head_data;
  logic [WIDTH-1:0] cur_val;
  logic [WIDTH-1:0] commit_val;
  logic             reg_we;

  // Handshake: ready depends only on occupancy, so a full queue never
  // accepts even if the head commits on the same edge.
  always_comb begin
    wb_ready = (count < DEPTH_C);
    enq      = wb_valid & wb_ready;
    deq      = commit_en & (count != {CW{1'b0}});
  end

  // Head entry decode and the value it will write back.
  always_comb begin
    head_addr = q_addr[head];
    head_mode = q_mode[head];
    head_data = q_data[head];
    cur_val   = regs[head_addr];
    case (head_mode)
      2'b00:   commit_val = head_data;
      2'b01:   commit_val = {cur_val[WIDTH-1:8], head_data[7:0]};
      2'b10:   commit_val = {head_data[7:0], cur_val[WIDTH-9:0]};
      2'b11:   commit_val = cur_val + head_data;
      default: commit_val = cur_val;
    endcase
    // With ZERO_R0 a commit to r0 still retires the entry but writes nothing.
    if ((ZERO_R0 != 0) && (head_addr == 3'd0)) begin
      reg_we = 1'b0;
    end else begin
      reg_we = deq;
    end
  end

  // Occupancy next-state.
  always_comb begin
    case ({enq, deq})
      2'b10:   count_next = count + CW'(1);
      2'b01:   count_next = count - CW'(1);
      default: count_next = count;
    endcase
  end

  // Queue storage and pointers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        q_addr[i] <= 3'd0;
        q_mode[i] <= 2'b00;
        q_data[i] <= {WIDTH{1'b0}};
      end
      q_vld <= {DEPTH{1'b0}};
      head  <= {PW{1'b0}};
      tail  <= {PW{1'b0}};
      count <= {CW{1'b0}};
    end else begin
      // Enqueue and dequeue never hit the same slot: that would need the
      // queue to be both empty (head==tail, nothing to commit) and not full.
      if (enq) begin
        q_addr[tail] <= wb_addr;
        q_mode[tail] <= wb_mode;
        q_data[tail] <= wb_data;
        q_vld[tail]  <= 1'b1;
        tail         <= ptr_inc(tail);
      end
      if (deq) begin
        q_vld[head] <= 1'b0;
        head        <= ptr_inc(head);
      end
      count <= count_next;
    end
  end

  // Register bank write port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) begin
        regs[i] <= {WIDTH{1'b0}};
      end
    end else if (reg_we) begin
      regs[head_addr] <= commit_val;
    end
  end

  // Commit status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      commit_pulse <= 1'b0;
      commit_addr  <= 3'd0;
    end else begin
      commit_pulse <= deq;
      if (deq) begin
        commit_addr <= head_addr;
      end
    end
  end

  // Scoreboard: one-hot OR of every occupied slot's target.
  always_comb begin
    pending = 8'h00;
    for (int i = 0; i < DEPTH; i++) begin
      if (q_vld[i]) begin
        pending[q_addr[i]] = 1'b1;
      end else begin
        pending = pending;
      end
    end
  end

  assign q_count = count;
  assign r0 = regs[0];
  assign r1 = regs[1];
  assign r2 = regs[2];
  assign r3 = regs[3];
  assign r4 = regs[4];
  assign r5 = regs[5];
  assign r6 = regs[6];
  assign r7 = regs[7];

endmodule

// File: tb/tb_regbank_wbq.sv
// Testbench for regbank_wbq. Two instances share all inputs: one with
// ZERO_R0=0 and one with ZERO_R0=1. A queue-based reference model is stepped
// on every clock edge and compared against both instances, alongside a table
// of directed vectors and hand-written corner-case sequences.
module tb_regbank_wbq;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wb_valid = 1'b0;
  logic [2:0]  wb_addr = 3'd0;
  logic [1:0]  wb_mode = 2'b00;
  logic [15:0] wb_data = 16'h0000;
  logic        commit_en = 1'b0;

  logic        rdy [2];
  logic [15:0] ra [8];
  logic [15:0] rz [8];
  logic [7:0]  pend [2];
  logic [1:0]  qc [2];
  logic        cp [2];
  logic [2:0]  ca [2];

  always #5 clk = ~clk;

  regbank_wbq #(.WIDTH(16), .DEPTH(DEPTH), .ZERO_R0(0)) dut (
    .clk(clk), .rst_n(rst_n), .wb_valid(wb_valid), .wb_ready(rdy[0]),
    .wb_addr(wb_addr), .wb_mode(wb_mode), .wb_data(wb_data), .commit_en(commit_en),
    .r0(ra[0]), .r1(ra[1]), .r2(ra[2]), .r3(ra[3]),
    .r4(ra[4]), .r5(ra[5]), .r6(ra[6]), .r7(ra[7]),
    .pending(pend[0]), .q_count(qc[0]), .commit_pulse(cp[0]), .commit_addr(ca[0])
  );

  regbank_wbq #(.WIDTH(16), .DEPTH(DEPTH), .ZERO_R0(1)) dutz (
    .clk(clk), .rst_n(rst_n), .wb_valid(wb_valid), .wb_ready(rdy[1]),
    .wb_addr(wb_addr), .wb_mode(wb_mode), .wb_data(wb_data), .commit_en(commit_en),
    .r0(rz[0]), .r1(rz[1]), .r2(rz[2]), .r3(rz[3]),
    .r4(rz[4]), .r5(rz[5]), .r6(rz[6]), .r7(rz[7]),
    .pending(pend[1]), .q_count(qc[1]), .commit_pulse(cp[1]), .commit_addr(ca[1])
  );

  // ---------------- reference model ----------------
  typedef struct {
    logic [2:0]  a;
    logic [1:0]  m;
    logic [15:0] d;
  } ent_t;

  ent_t        mq[$];
  logic [15:0] mregs [2][8];
  logic        mpulse;
  logic [2:0]  maddr;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < 8; i++) mregs[k][i] = 16'h0000;
    mpulse = 1'b0;
    maddr  = 3'd0;
  endtask

  function automatic logic [15:0] apply(input logic [15:0] old, input ent_t e);
    int v;
    case (e.m)
      2'd0:    v = e.d;
      2'd1:    v = (old & 16'hFF00) | (e.d & 16'h00FF);
      2'd2:    v = ((e.d & 16'h00FF) * 256) + (old & 16'h00FF);
      default: v = (int'(old) + int'(e.d)) % 65536;
    endcase
    return v[15:0];
  endfunction

  function automatic logic [7:0] model_pending();
    logic [7:0] p = 8'h00;
    foreach (mq[i]) p = p | (8'h01 << mq[i].a);
    return p;
  endfunction

  // One clock edge of the model, using the inputs presented before the edge.
  task automatic model_step();
    bit   acc;
    bit   com;
    ent_t e;
    acc = wb_valid && (mq.size() < DEPTH);
    com = commit_en && (mq.size() > 0);
    if (com) begin
      e = mq.pop_front();
      mregs[0][e.a] = apply(mregs[0][e.a], e);
      if (e.a != 3'd0) mregs[1][e.a] = apply(mregs[1][e.a], e);
      maddr = e.a;
    end
    mpulse = com;
    if (acc) begin
      e.a = wb_addr; e.m = wb_mode; e.d = wb_data;
      mq.push_back(e);
    end
  endtask

  task automatic check_model(input string tag);
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("%s i%0d wb_ready", tag, k), 32'(rdy[k]), 32'(mq.size() < DEPTH));
      chk($sformatf("%s i%0d q_count", tag, k), 32'(qc[k]), 32'(mq.size()));
      chk($sformatf("%s i%0d pending", tag, k), 32'(pend[k]), 32'(model_pending()));
      chk($sformatf("%s i%0d commit_pulse", tag, k), 32'(cp[k]), 32'(mpulse));
      chk($sformatf("%s i%0d commit_addr", tag, k), 32'(ca[k]), 32'(maddr));
      for (int i = 0; i < 8; i++)
        chk($sformatf("%s i%0d r%0d", tag, k, i),
            32'((k == 0) ? ra[i] : rz[i]), 32'(mregs[k][i]));
    end
  endtask

  // Advance one clock: model follows the edge, then everything is checked on
  // the falling edge. Callers change inputs right after this returns.
  task automatic tick(input string tag);
    @(posedge clk);
    if (rst_n) model_step();
    else model_reset();
    @(negedge clk);
    check_model(tag);
  endtask

  task automatic drive(input logic v, input logic [2:0] a, input logic [1:0] m,
                       input logic [15:0] d, input logic ce);
    wb_valid = v; wb_addr = a; wb_mode = m; wb_data = d; commit_en = ce;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    drive(1'b0, 3'd0, 2'b00, 16'h0000, 1'b0);
    model_reset();
    tick("reset");
    rst_n = 1'b1;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic        v;
    logic [2:0]  a;
    logic [1:0]  m;
    logic [15:0] d;
    logic        ce;
    logic [2:0]  ra;
    logic [15:0] rexp;
    logic [1:0]  qc;
    logic [7:0]  pend;
    logic        rdy;
    logic        cp;
    logic [2:0]  ca;
  } vec_t;

  function automatic vec_t mk(input logic v, input logic [2:0] a, input logic [1:0] m,
                              input logic [15:0] d, input logic ce, input logic [2:0] rx,
                              input logic [15:0] rexp, input logic [1:0] q,
                              input logic [7:0] p, input logic r, input logic c,
                              input logic [2:0] cadr);
    vec_t t;
    t.v = v; t.a = a; t.m = m; t.d = d; t.ce = ce; t.ra = rx; t.rexp = rexp;
    t.qc = q; t.pend = p; t.rdy = r; t.cp = c; t.ca = cadr;
    return t;
  endfunction

  vec_t vec [17];

  initial begin
    // Word write to r3.
    vec[0]  = mk(1, 3'd3, 2'd0, 16'h1234, 1, 3'd3, 16'h0000, 2'd1, 8'h08, 1, 0, 3'd0);
    vec[1]  = mk(0, 3'd0, 2'd0, 16'h0000, 1, 3'd3, 16'h1234, 2'd0, 8'h00, 1, 1, 3'd3);
    // Accumulate into r5 with wrap.
    vec[2]  = mk(1, 3'd5, 2'd0, 16'h00FF, 1, 3'd5, 16'h0000, 2'd1, 8'h20, 1, 0, 3'd3);
    vec[3]  = mk(1, 3'd5, 2'd3, 16'h0001, 1, 3'd5, 16'h00FF, 2'd1, 8'h20, 1, 1, 3'd5);
    vec[4]  = mk(1, 3'd5, 2'd3, 16'hFFFF, 1, 3'd5, 16'h0100, 2'd1, 8'h20, 1, 1, 3'd5);
    vec[5]  = mk(0, 3'd0, 2'd0, 16'h0000, 1, 3'd5, 16'h00FF, 2'd0, 8'h00, 1, 1, 3'd5);
    vec[6]  = mk(0, 3'd0, 2'd0, 16'h0000, 0, 3'd5, 16'h00FF, 2'd0, 8'h00, 1, 0, 3'd5);
    // Fill queue, hold off a third request, drain in order.
    vec[7]  = mk(1, 3'd1, 2'd0, 16'hAAAA, 0, 3'd1, 16'h0000, 2'd1, 8'h02, 1, 0, 3'd5);
    vec[8]  = mk(1, 3'd2, 2'd0, 16'hBBBB, 0, 3'd2, 16'h0000, 2'd2, 8'h06, 0, 0, 3'd5);
    vec[9]  = mk(1, 3'd6, 2'd0, 16'h5555, 0, 3'd6, 16'h0000, 2'd2, 8'h06, 0, 0, 3'd5);
    vec[10] = mk(1, 3'd6, 2'd0, 16'h5555, 1, 3'd1, 16'hAAAA, 2'd1, 8'h04, 1, 1, 3'd1);
    vec[11] = mk(0, 3'd0, 2'd0, 16'h0000, 1, 3'd2, 16'hBBBB, 2'd0, 8'h00, 1, 1, 3'd2);
    vec[12] = mk(0, 3'd0, 2'd0, 16'h0000, 0, 3'd6, 16'h0000, 2'd0, 8'h00, 1, 0, 3'd2);
    // Byte-lane writes to r7.
    vec[13] = mk(1, 3'd7, 2'd0, 16'h1234, 1, 3'd7, 16'h0000, 2'd1, 8'h80, 1, 0, 3'd2);
    vec[14] = mk(1, 3'd7, 2'd1, 16'h00CD, 1, 3'd7, 16'h1234, 2'd1, 8'h80, 1, 1, 3'd7);
    vec[15] = mk(1, 3'd7, 2'd2, 16'h00EF, 1, 3'd7, 16'h12CD, 2'd1, 8'h80, 1, 1, 3'd7);
    vec[16] = mk(0, 3'd0, 2'd0, 16'h0000, 1, 3'd7, 16'hEFCD, 2'd0, 8'h00, 1, 1, 3'd7);
  end

  // ---------------- main sequence ----------------
  initial begin
    model_reset();
    @(negedge clk);
    #1;
    check_model("por");
    do_reset();

    // Table-driven directed vectors.
    for (int i = 0; i < 17; i++) begin
      drive(vec[i].v, vec[i].a, vec[i].m, vec[i].d, vec[i].ce);
      tick($sformatf("vec%0d", i));
      chk($sformatf("vec%0d r%0d", i, vec[i].ra), 32'(ra[vec[i].ra]), 32'(vec[i].rexp));
      chk($sformatf("vec%0d q_count", i), 32'(qc[0]), 32'(vec[i].qc));
      chk($sformatf("vec%0d pending", i), 32'(pend[0]), 32'(vec[i].pend));
      chk($sformatf("vec%0d wb_ready", i), 32'(rdy[0]), 32'(vec[i].rdy));
      chk($sformatf("vec%0d commit_pulse", i), 32'(cp[0]), 32'(vec[i].cp));
      chk($sformatf("vec%0d commit_addr", i), 32'(ca[0]), 32'(vec[i].ca));
    end

    // Two queued writes to r4: pending[4] holds until the second commits.
    drive(1, 3'd4, 2'd0, 16'h0001, 0); tick("r4a");
    drive(1, 3'd4, 2'd3, 16'h0002, 0); tick("r4b");
    chk("r4 pending both", 32'(pend[0]), 32'h10);
    drive(0, 3'd0, 2'd0, 16'h0000, 1); tick("r4c");
    chk("r4 first commit", 32'(ra[4]), 32'h0001);
    chk("r4 pending after first", 32'(pend[0][4]), 32'h1);
    tick("r4d");
    chk("r4 second commit", 32'(ra[4]), 32'h0003);
    chk("r4 pending after second", 32'(pend[0][4]), 32'h0);

    // ZERO_R0: the commit retires and pulses but r0 stays zero.
    drive(1, 3'd0, 2'd0, 16'hFFFF, 1); tick("z0a");
    drive(0, 3'd0, 2'd0, 16'h0000, 1); tick("z0b");
    chk("zero_r0 r0", 32'(rz[0]), 32'h0000);
    chk("zero_r0 pulse", 32'(cp[1]), 32'h1);
    chk("zero_r0 addr", 32'(ca[1]), 32'h0);
    chk("normal r0", 32'(ra[0]), 32'hFFFF);

    // Mid-operation reset with two entries queued.
    drive(1, 3'd1, 2'd0, 16'h1111, 0); tick("mr1");
    drive(1, 3'd2, 2'd0, 16'h2222, 0); tick("mr2");
    chk("mr queued", 32'(qc[0]), 32'h2);
    rst_n = 1'b0;
    drive(0, 3'd0, 2'd0, 16'h0000, 1);
    model_reset();
    #1;
    check_model("async_rst");
    chk("async q_count", 32'(qc[1]), 32'h0);
    chk("async r0 normal", 32'(ra[0]), 32'h0000);
    tick("rst_hold");
    rst_n = 1'b1;
    tick("post_rst1");
    tick("post_rst2");
    chk("discarded r1", 32'(ra[1]), 32'h0000);
    chk("discarded r2", 32'(ra[2]), 32'h0000);
    chk("discarded pulse", 32'(cp[0]), 32'h0);

    // Randomized traffic against the model, with occasional resets.
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 149) == 0) begin
        rst_n = 1'b0;
        model_reset();
        #1;
        check_model("rnd_async");
        tick("rnd_rst");
        rst_n = 1'b1;
      end
      drive(1'($urandom_range(0, 9) < 6), 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)),
            16'($urandom), 1'($urandom_range(0, 9) < 5));
      tick("rnd");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/regbank_wbq.md
Name: regbank_wbq

Overview:
- Eight-entry general-purpose register bank of the datapath.
- Its eight register outputs r0..r7 feed the 8:1 operand read multiplexer directly.
- Writes from the execute/write-back path enter a small in-order write queue and commit to the bank one per cycle when the downstream read side permits (commit_en).
- Exposes a per-register pending scoreboard so control logic can detect read-after-write hazards.

Parameters:
- WIDTH, 16, register/data width in bits.
- DEPTH, 2, write-queue entries (>=1).
- ZERO_R0, 0, when 1 r0 is hardwired to zero and writes to it are discarded at commit.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- wb_valid  in  1  write request valid.
- wb_ready  out  1  queue can accept a request this cycle.
- wb_addr  in  3  target register index.
- wb_mode  in  2  00 word write, 01 low-byte write, 10 high-byte write, 11 accumulate (add).
- wb_data  in  WIDTH  write operand.
- commit_en  in  1  permits head of queue to commit this cycle.
- r0..r7  out  WIDTH each  current register contents (registered, no bypass).
- pending  out  8  bit i = 1 while any queued entry targets register i.
- q_count  out  $clog2(DEPTH+1)  entries currently queued.
- commit_pulse  out  1  registered; 1 for one cycle after an entry commits.
- commit_addr  out  3  registered; index of last committed entry.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - r0..r7 = 0; queue empty; q_count = 0; pending = 0.
  - commit_pulse = 0; commit_addr = 0.
  - wb_ready = 1 (combinational from q_count).
- wb_ready = (q_count < DEPTH). No pass-through when full: a request presented while full is not accepted, even if a commit happens the same cycle.
- Enqueue: on a rising edge with wb_valid && wb_ready, {addr, mode, data} is written at the tail.
- Dequeue/commit: on a rising edge with commit_en && q_count>0, the head entry is applied to its register and removed.
- Simultaneous enqueue and commit: q_count unchanged; order preserved.
- Latency: an entry accepted at edge N is visible on rX no earlier than edge N+1 (empty queue, commit_en=1). The queue never bypasses to r outputs.
- Commit arithmetic, using the register value before the edge:
  - 00: reg <= data.
  - 01: reg <= {reg[WIDTH-1:8], data[7:0]}.
  - 10: reg <= {data[7:0], reg[7:0]}.
  - 11: reg <= reg + data, modulo 2^WIDTH; carry discarded.
- ZERO_R0=1: commits to r0 still dequeue and pulse commit_pulse, but r0 stays 0.
- pending: combinational OR over valid queue entries of one-hot(addr).
  - Clears in the same cycle the last entry for that register commits (after the edge).
  - Multiple queued writes to the same register keep the bit set until all have committed.
- commit_pulse/commit_addr are updated on each edge:
  - pulse = 1 iff a commit occurred at that edge.
  - addr is updated only on a commit.
- Queue pointers wrap modulo DEPTH. With DEPTH=1 the block alternates accept/commit.
- Reset asserted mid-operation: queued writes are discarded (not committed) and all registers clear immediately.
- wb_addr/wb_mode/wb_data are ignored when not accepted.

Test Plan:
- Reset, then wb_valid with addr=3, mode=00, data=0x1234, commit_en=1 → next edge r3=0x1234, commit_pulse=1, commit_addr=3, pending=0; other registers 0.
- r5=0x00FF; queue mode=11 data=0x0001, then mode=11 data=0xFFFF (commit_en=1) → r5 goes 0x0100, then 0x00FF (wrap, carry dropped).
- commit_en=0; enqueue addr=1 data=0xAAAA and addr=2 data=0xBBBB → q_count=2, wb_ready=0, pending=0x06. A third request is held off. Raise commit_en → r1=0xAAAA, then r2=0xBBBB, in order; wb_ready returns to 1 after the first commit.
- r7=0x1234; mode=01 data=0x00CD → r7=0x12CD; then mode=10 data=0x00EF → r7=0xEFCD.
- Queue two writes to r4 with commit_en=0 → pending[4] stays 1 after the first commit and clears only after the second.
- ZERO_R0=1: write 0xFFFF to r0 → r0 remains 0, commit_pulse=1. Then, with two entries queued, assert rst_n=0 for one cycle → q_count=0, pending=0, all r=0, and the queued writes are never applied.
